// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter
// N-channel arbiter with a registered one-hot grant and an encoded winner index.
// The grant stays with its owner while the owner keeps requesting. The owner can
// be preempted once it has held the grant for MAX_HOLD cycles while another
// channel waits. Winners are picked by rotating priority or by fixed priority.
// All outputs come straight from registers.
module rr_hold_arbiter #(
    parameter int N           = 4,
    parameter int ROUND_ROBIN = 1,
    parameter int MAX_HOLD    = 4,
    // Derived from N; leave at its default.
    parameter int IDW         = (N > 2) ? $clog2(N) : 1
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic [N-1:0]   i_req,
    output logic [N-1:0]   o_gnt,
    output logic           o_gnt_valid,
    output logic [IDW-1:0] o_gnt_id,
    output logic           o_timeout
);

    // The hold counter only needs to reach MAX_HOLD-1. When there is no timeout
    // it stays parked at zero.
    localparam int             HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_gnt;
    logic           r_gnt_valid;
    logic [IDW-1:0] r_gnt_id;
    logic           r_timeout;
    logic [IDW-1:0] r_ptr;
    logic [HCW-1:0] r_hold_cnt;

    state_t         w_state_next;
    logic [N-1:0]   w_gnt_next;
    logic [IDW-1:0] w_gnt_id_next;
    logic           w_timeout_next;
    logic [IDW-1:0] w_ptr_next;
    logic [HCW-1:0] w_hold_next;
    logic           w_load;

    logic [N-1:0]   w_cand;
    logic [N-1:0]   w_upper_mask;
    logic [N-1:0]   w_cand_upper;
    logic           w_use_upper;
    logic [IDW-1:0] w_winner;
    logic [N-1:0]   w_winner_oh;
    logic [IDW-1:0] w_ptr_after;
    logic           w_owner_req;
    logic           w_hold_sat;
    logic           w_preempt;
    logic [HCW-1:0] w_hold_inc;

    // Index of the lowest set bit. Returns 0 for an all-zero vector, which is
    // never used because a load only happens when some candidate is set.
    function automatic logic [IDW-1:0] f_lowest(input logic [N-1:0] v);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDW'(i);
            end
        end
        return idx;
    endfunction

    // Candidates for a new grant are the requesters other than the current
    // owner. On a release the owner's request is already low. In IDLE r_gnt is
    // zero. So this single mask serves every case.
    assign w_cand      = i_req & ~r_gnt;
    assign w_owner_req = |(i_req & r_gnt);

    // Channels at or above the rotating pointer. Scanning these first and then
    // falling back to the whole vector gives the wrap-around search order.
    for (genvar gi = 0; gi < N; gi++) begin : g_upper
        assign w_upper_mask[gi] = (IDW'(gi) >= r_ptr);
    end

    assign w_cand_upper = w_cand & w_upper_mask;
    assign w_use_upper  = (ROUND_ROBIN != 0) && (|w_cand_upper);

    // Pick the winner. With fixed priority this is the lowest candidate index.
    always_comb begin
        w_winner = w_use_upper ? f_lowest(w_cand_upper) : f_lowest(w_cand);
    end

    // Turn the winner index into a one-hot grant.
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign w_winner_oh[gi] = (w_winner == IDW'(gi));
    end

    // After a grant the pointer moves to the channel just past the winner.
    assign w_ptr_after = (w_winner == IDW'(N - 1)) ? '0 : (w_winner + IDW'(1));

    // Preempt only when the hold counter is saturated and someone else waits.
    assign w_hold_sat = (r_hold_cnt == HOLD_LAST);
    assign w_preempt  = (MAX_HOLD > 0) && w_hold_sat && (|w_cand);
    assign w_hold_inc = w_hold_sat ? r_hold_cnt : (r_hold_cnt + HCW'(1));

    // Next-state and next-output logic. Release takes precedence over
    // preemption, so a simultaneous release never raises the timeout flag.
    always_comb begin
        w_state_next   = r_state;
        w_gnt_next     = r_gnt;
        w_gnt_id_next  = r_gnt_id;
        w_timeout_next = 1'b0;
        w_ptr_next     = r_ptr;
        w_hold_next    = r_hold_cnt;
        w_load         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_gnt_next = '0;
                if (|i_req) begin
                    w_load = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req) begin
                    if (|i_req) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_gnt_next   = '0;
                    end
                end else if (w_preempt) begin
                    w_load         = 1'b1;
                    w_timeout_next = 1'b1;
                end else begin
                    w_hold_next = w_hold_inc;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = '0;
            end
        endcase

        // Every new grant: publish the winner, advance the pointer, restart hold.
        if (w_load) begin
            w_state_next  = ST_GRANT;
            w_gnt_next    = w_winner_oh;
            w_gnt_id_next = w_winner;
            w_ptr_next    = w_ptr_after;
            w_hold_next   = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_timeout   <= 1'b0;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_gnt       <= w_gnt_next;
            r_gnt_valid <= |w_gnt_next;
            r_gnt_id    <= w_gnt_id_next;
            r_timeout   <= w_timeout_next;
            r_ptr       <= w_ptr_next;
            r_hold_cnt  <= w_hold_next;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_valid = r_gnt_valid;
    assign o_gnt_id    = r_gnt_id;
    assign o_timeout   = r_timeout;

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Parametrised N-channel arbiter that grants one requester at a time from a shared resource. It is the successor to the two-channel arbiter and supports both round-robin and fixed-priority selection. A grant is held while the owner keeps requesting, with optional timeout preemption. The grant is registered, and an encoded winner index is provided for downstream muxes.

## Interface
- N, 4, number of request channels (N ≥ 2)
- ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority with index 0 highest
- MAX_HOLD, 4, maximum cycles a grant may be held while others wait; 0 = no timeout
- IDW, max(1,$clog2(N)), width of gnt_id (derived, do not override)
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- req  input  N  per-channel request, level, sampled each rising edge
- gnt  output  N  one-hot registered grant, or all-zero when idle
- gnt_valid  output  1  OR of gnt
- gnt_id  output  IDW  index of the granted channel; holds its last value when idle
- timeout  output  1  one-cycle pulse on the cycle a grant begins because the previous owner was preempted

## Operation
- State machine:
  - IDLE: gnt = 0.
    - If req ≠ 0 at an edge: winner gets gnt, go to GRANT.
  - GRANT: owner = gnt_id. Evaluated at each edge in this order:
    1. req[owner] = 0 and req ≠ 0: grant moves to the winner of the current req, with no gap cycle; timeout = 0.
    2. req[owner] = 0 and req = 0: go to IDLE, gnt = 0.
    3. MAX_HOLD > 0 and hold_cnt = MAX_HOLD−1 and (req & ~gnt) ≠ 0: preempt. Grant moves to the winner of req & ~gnt; timeout = 1 for that cycle.
    4. Otherwise: grant held.
- Winner selection:
  - ROUND_ROBIN = 1: first set bit scanning upward from ptr, wrapping N−1 → 0.
  - ROUND_ROBIN = 0: lowest set index.
- Priority pointer:
  - Each new grant loads ptr ← (winner+1) mod N; winner N−1 loads ptr = 0.
  - ptr is unchanged while a grant is held or in IDLE.
  - ptr is unused when ROUND_ROBIN = 0.
- hold_cnt:
  - Width covers 0..MAX_HOLD−1.
  - Set to 0 on the first cycle of every new grant, including a handoff to a different channel.
  - Increments each held cycle and saturates at MAX_HOLD−1.
  - A lone owner therefore keeps its grant indefinitely. It is preempted on the first edge another request is present once saturated.
- Reset, including mid-grant: gnt = 0, gnt_valid = 0, gnt_id = 0, timeout = 0, ptr = 0, hold_cnt = 0, state IDLE. Requests present during reset are ignored until the first edge after reset deasserts.
- gnt is never multi-hot. gnt_id always equals the index of the set gnt bit when gnt_valid = 1.

## Timing
- Request-to-grant latency: 1 cycle. req sampled at edge k gives gnt visible after edge k.
- Release-to-handoff: owner req low at edge k means the new owner's gnt is visible after edge k. gnt never overlaps and no bubble is inserted.
- An owner is guaranteed exactly MAX_HOLD granted cycles before preemption if others wait continuously.
- timeout is high only in the first cycle of the preempting grant.
- All outputs are registered; there are no combinational paths from req to outputs.
- Simultaneous owner-release and timeout condition: release rule applies, so timeout = 0.

## Test plan
Default parameters N=4, MAX_HOLD=4 unless stated.
- Reset mid-grant: hold req = 0010 and assert reset for 1 cycle while gnt = 0010 → gnt = 0000, gnt_id = 0, timeout = 0 next cycle. gnt = 0010 returns one edge after reset drops.
- Release handoff: from IDLE, req = 0101 → gnt = 0001 one cycle later. Drop req[0] → gnt = 0100 on the following cycle with no zero gap. Drop all → gnt = 0000, gnt_id stays 2.
- Round-robin rotation: req = 1111 held constant → gnt sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001. timeout = 1 on the first cycle of each grant after the first.
- Fixed priority (ROUND_ROBIN=0): req = 1111 held → gnt alternates 0001×4, 0010×4, 0001×4. Channels 2 and 3 are never granted. timeout pulses at each switch.
- Lone owner: req = 0100 for 10 cycles → gnt = 0100 throughout and timeout stays 0. Assert req[3] on cycle 10 → gnt = 1000 the next cycle with timeout = 1.
- No timeout (MAX_HOLD=0): req = 0011 held 20 cycles → gnt = 0001 for all cycles and timeout never asserts.
